// File: rtl/mbinit_param_responder_pkg.sv
// Shared MBINIT definitions: sideband opcodes, data-rate width, responder
// state encoding, the capability record exchanged in PARAM messages, and
// the rate-resolution helper.
package mbinit_param_responder_pkg;

    localparam int RATE_W   = 3;
    localparam int OPCODE_W = 4;
    localparam int VSWING_W = 5;

    localparam logic [OPCODE_W-1:0] SB_CONFIG_REQ  = 4'b0001;
    localparam logic [OPCODE_W-1:0] SB_CONFIG_RESP = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_REQ  = 3'd1,
        ST_RESOLVE   = 3'd2,
        ST_SEND_RESP = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } param_state_e;

    // Capabilities carried by a PARAM message (or held locally).
    typedef struct packed {
        logic [RATE_W-1:0] max_data_rate;
        logic              clock_mode;
        logic              phase_clock;
    } param_caps_t;

    // Both sides must support the negotiated rate, so the lower code wins.
    function automatic logic [RATE_W-1:0] rate_min(input logic [RATE_W-1:0] a,
                                                   input logic [RATE_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/mbinit_param_responder_if.sv
// Sideband message bus seen by the PARAM responder: decoded RX message
// fields, TX busy status, and the TX message request with its parameters.
interface mbinit_param_responder_if;
    import mbinit_param_responder_pkg::*;

    // RX side and TX status, produced by the sideband block
    logic [OPCODE_W-1:0] i_RX_SbMessage;
    logic                i_msg_valid;
    logic [RATE_W-1:0]   i_RX_MaxDataRate;
    logic                i_RX_ClockMode;
    logic                i_RX_PhaseClock;
    logic                i_Busy_SideBand;
    logic                i_falling_edge_busy;

    // TX request, produced by the responder
    logic [OPCODE_W-1:0] o_TX_SbMessage;
    logic                o_ValidOutDatat_Module;
    logic                o_ValidDataFieldParameters;
    logic [VSWING_W-1:0] o_TX_VoltageSwing;
    logic [RATE_W-1:0]   o_MaxDataRate;
    logic                o_TX_ClockMode;
    logic                o_TX_PhaseClock;

    // Sideband block side
    modport master (
        output i_RX_SbMessage, i_msg_valid, i_RX_MaxDataRate, i_RX_ClockMode,
               i_RX_PhaseClock, i_Busy_SideBand, i_falling_edge_busy,
        input  o_TX_SbMessage, o_ValidOutDatat_Module, o_ValidDataFieldParameters,
               o_TX_VoltageSwing, o_MaxDataRate, o_TX_ClockMode, o_TX_PhaseClock
    );

    // Responder side
    modport slave (
        input  i_RX_SbMessage, i_msg_valid, i_RX_MaxDataRate, i_RX_ClockMode,
               i_RX_PhaseClock, i_Busy_SideBand, i_falling_edge_busy,
        output o_TX_SbMessage, o_ValidOutDatat_Module, o_ValidDataFieldParameters,
               o_TX_VoltageSwing, o_MaxDataRate, o_TX_ClockMode, o_TX_PhaseClock
    );

endinterface

// File: rtl/mbinit_param_resolver.sv
// Combinational PARAM resolution: lower of the two rate codes, AND of the
// clock-mode and phase-clock options, plus a flag for an unusable (zero) rate.
module mbinit_param_resolver
    import mbinit_param_responder_pkg::*;
(
    input  param_caps_t remote_caps,
    input  param_caps_t local_caps,
    output param_caps_t resolved_caps,
    output logic        rate_zero
);

    // Resolve each field independently; a zero rate means no common rate.
    always_comb begin
        resolved_caps.max_data_rate = rate_min(remote_caps.max_data_rate,
                                               local_caps.max_data_rate);
        resolved_caps.clock_mode    = remote_caps.clock_mode  & local_caps.clock_mode;
        resolved_caps.phase_clock   = remote_caps.phase_clock & local_caps.phase_clock;
        rate_zero                   = (resolved_caps.max_data_rate == '0);
    end

endmodule

// File: rtl/mbinit_param_responder.sv
// MBINIT.PARAM responder: waits for the partner's configuration_req,
// resolves it against local capabilities, answers with configuration_resp,
// and reports done or a training error to the MBINIT sequencer.
module mbinit_param_responder
    import mbinit_param_responder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int CNT_W          = 12
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    i_MBINIT_Start_en,
    input  logic [RATE_W-1:0]       i_Local_MaxDataRate,
    input  logic                    i_Local_ClockMode,
    input  logic                    i_Local_PhaseClock,
    mbinit_param_responder_if.slave sb,
    output logic [RATE_W-1:0]       o_Final_MaxDataRate,
    output logic                    o_MBINIT_PARAM_Resp_end,
    output logic                    o_train_error_req
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    param_state_e      cs_reg;
    param_state_e      state_next;
    logic [CNT_W-1:0]  cnt_reg;
    param_caps_t       cap_reg;
    param_caps_t       local_caps;
    param_caps_t       resolved_caps;
    logic              rate_zero;
    logic              req_seen;

    logic [OPCODE_W-1:0] tx_msg_reg;
    logic                tx_valid_reg;
    logic [RATE_W-1:0]   tx_rate_reg;
    logic                tx_clk_reg;
    logic                tx_ph_reg;
    logic [RATE_W-1:0]   final_rate_reg;
    logic                end_reg;
    logic                err_reg;

    assign local_caps = {i_Local_MaxDataRate, i_Local_ClockMode, i_Local_PhaseClock};
    assign req_seen   = sb.i_msg_valid && (sb.i_RX_SbMessage == SB_CONFIG_REQ);

    mbinit_param_resolver u_resolver (
        .remote_caps   (cap_reg),
        .local_caps    (local_caps),
        .resolved_caps (resolved_caps),
        .rate_zero     (rate_zero)
    );

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cs_reg <= ST_IDLE;
        end else begin
            cs_reg <= state_next;
        end
    end

    // Next-state logic; a low enable overrides every other event.
    always_comb begin
        state_next = cs_reg;
        if (!i_MBINIT_Start_en) begin
            state_next = ST_IDLE;
        end else begin
            case (cs_reg)
                ST_IDLE:      state_next = ST_WAIT_REQ;
                ST_WAIT_REQ: begin
                    // A request arriving on the timeout cycle still wins.
                    if (req_seen) begin
                        state_next = ST_RESOLVE;
                    end else if (cnt_reg == TIMEOUT_VAL) begin
                        state_next = ST_ERROR;
                    end
                end
                ST_RESOLVE: begin
                    if (rate_zero) begin
                        state_next = ST_ERROR;
                    end else if (!sb.i_Busy_SideBand) begin
                        state_next = ST_SEND_RESP;
                    end
                end
                ST_SEND_RESP: begin
                    if (sb.i_falling_edge_busy) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE:      state_next = ST_DONE;
                ST_ERROR:     state_next = ST_ERROR;
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    // Timeout counter (cleared while idle) and capture of the partner's request.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            cap_reg <= '0;
        end else begin
            if (cs_reg == ST_IDLE) begin
                cnt_reg <= '0;
            end else if (cs_reg == ST_WAIT_REQ) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if ((cs_reg == ST_WAIT_REQ) && (state_next == ST_RESOLVE)) begin
                cap_reg <= {sb.i_RX_MaxDataRate, sb.i_RX_ClockMode, sb.i_RX_PhaseClock};
            end
        end
    end

    // Registered outputs decoded from the next state so they line up with state entry.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            tx_msg_reg     <= '0;
            tx_valid_reg   <= 1'b0;
            tx_rate_reg    <= '0;
            tx_clk_reg     <= 1'b0;
            tx_ph_reg      <= 1'b0;
            final_rate_reg <= '0;
            end_reg        <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            if (state_next == ST_SEND_RESP) begin
                tx_msg_reg   <= SB_CONFIG_RESP;
                tx_valid_reg <= 1'b1;
                tx_rate_reg  <= resolved_caps.max_data_rate;
                tx_clk_reg   <= resolved_caps.clock_mode;
                tx_ph_reg    <= resolved_caps.phase_clock;
            end else begin
                tx_msg_reg   <= '0;
                tx_valid_reg <= 1'b0;
                tx_rate_reg  <= '0;
                tx_clk_reg   <= 1'b0;
                tx_ph_reg    <= 1'b0;
            end
            // Latched only on a real completion, so an abort keeps the old value.
            if ((cs_reg == ST_SEND_RESP) && (state_next == ST_DONE)) begin
                final_rate_reg <= resolved_caps.max_data_rate;
            end
            end_reg <= (state_next == ST_DONE);
            err_reg <= (state_next == ST_ERROR) && (cs_reg != ST_ERROR);
        end
    end

    assign sb.o_TX_SbMessage             = tx_msg_reg;
    assign sb.o_ValidOutDatat_Module     = tx_valid_reg;
    assign sb.o_ValidDataFieldParameters = tx_valid_reg;
    assign sb.o_TX_VoltageSwing          = '0;
    assign sb.o_MaxDataRate              = tx_rate_reg;
    assign sb.o_TX_ClockMode             = tx_clk_reg;
    assign sb.o_TX_PhaseClock            = tx_ph_reg;
    assign o_Final_MaxDataRate           = final_rate_reg;
    assign o_MBINIT_PARAM_Resp_end       = end_reg;
    assign o_train_error_req             = err_reg;

endmodule

// File: tb/tb_mbinit_param_responder.sv
// Testbench for mbinit_param_responder: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the PARAM exchange.
module tb_mbinit_param_responder;
    import mbinit_param_responder_pkg::*;

    localparam int TMO = 8;
    localparam int CW  = 4;

    // Model phases of the exchange
    localparam int M_IDLE = 0, M_WAIT = 1, M_RES = 2, M_SEND = 3, M_DONE = 4, M_ERR = 5;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [2:0] loc_rate = 3'd5;
    logic       loc_clk = 1'b1;
    logic       loc_ph = 1'b0;
    logic [2:0] final_rate;
    logic       resp_end;
    logic       err_req;

    int n_cmp = 0;
    int n_bad = 0;

    mbinit_param_responder_if sb();

    mbinit_param_responder #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .CLK                     (CLK),
        .rst_n                   (rst_n),
        .i_MBINIT_Start_en       (en),
        .i_Local_MaxDataRate     (loc_rate),
        .i_Local_ClockMode       (loc_clk),
        .i_Local_PhaseClock      (loc_ph),
        .sb                      (sb),
        .o_Final_MaxDataRate     (final_rate),
        .o_MBINIT_PARAM_Resp_end (resp_end),
        .o_train_error_req       (err_req)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    int         m_ph = M_IDLE;
    int         m_age = 0;
    logic [2:0] m_rate = '0;
    logic       m_clk = 1'b0;
    logic       m_phc = 1'b0;
    logic [2:0] m_final = '0;
    logic       m_err = 1'b0;
    logic [20:0] exp_vec = '0;

    function automatic logic [20:0] dut_vec();
        return {sb.o_TX_SbMessage, sb.o_ValidOutDatat_Module, sb.o_ValidDataFieldParameters,
                sb.o_TX_VoltageSwing, sb.o_MaxDataRate, sb.o_TX_ClockMode, sb.o_TX_PhaseClock,
                final_rate, resp_end, err_req};
    endfunction

    task automatic model_reset();
        m_ph = M_IDLE; m_age = 0; m_rate = '0; m_clk = 1'b0; m_phc = 1'b0;
        m_final = '0; m_err = 1'b0; exp_vec = '0;
    endtask

    task automatic model_step();
        logic [2:0] r;
        r = (m_rate <= loc_rate) ? m_rate : loc_rate;
        m_err = 1'b0;
        if (!en) begin
            m_ph = M_IDLE;
        end else begin
            case (m_ph)
                M_IDLE: begin m_ph = M_WAIT; m_age = 0; end
                M_WAIT: begin
                    if (sb.i_msg_valid && sb.i_RX_SbMessage == 4'd1) begin
                        m_rate = sb.i_RX_MaxDataRate; m_clk = sb.i_RX_ClockMode;
                        m_phc = sb.i_RX_PhaseClock; m_ph = M_RES;
                    end else if (m_age == TMO) begin
                        m_ph = M_ERR; m_err = 1'b1;
                        $display("txn: error (timeout after %0d waiting cycles)", m_age + 1);
                    end else begin
                        m_age++;
                    end
                end
                M_RES: begin
                    if (r == 3'd0) begin
                        m_ph = M_ERR; m_err = 1'b1;
                        $display("txn: error (no common rate)");
                    end else if (!sb.i_Busy_SideBand) begin
                        m_ph = M_SEND;
                    end
                end
                M_SEND: begin
                    if (sb.i_falling_edge_busy) begin
                        m_final = r; m_ph = M_DONE;
                        $display("txn: resp done rate=%0d clk=%0d ph=%0d", r, m_clk & loc_clk, m_phc & loc_ph);
                    end
                end
                default: ;
            endcase
        end
        r = (m_rate <= loc_rate) ? m_rate : loc_rate;
        if (m_ph == M_SEND)
            exp_vec = {4'b0010, 1'b1, 1'b1, 5'd0, r, m_clk & loc_clk, m_phc & loc_ph, m_final, 1'b0, m_err};
        else
            exp_vec = {4'b0000, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, m_final, (m_ph == M_DONE), m_err};
    endtask

    initial begin
        forever begin
            @(posedge CLK or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare of every output against the model
    initial begin
        forever begin
            @(negedge CLK);
            n_cmp++;
            if (dut_vec() !== exp_vec) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t: got %h, required %h", $time, dut_vec(), exp_vec);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_req(input logic [2:0] rate, input logic c, input logic p);
        sb.i_msg_valid = 1'b1; sb.i_RX_SbMessage = 4'b0001;
        sb.i_RX_MaxDataRate = rate; sb.i_RX_ClockMode = c; sb.i_RX_PhaseClock = p;
        tick();
        sb.i_msg_valid = 1'b0; sb.i_RX_SbMessage = 4'b0000;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int errs;
        int seen;
        int first;
        int early;

        sb.i_RX_SbMessage = '0; sb.i_msg_valid = 1'b0; sb.i_RX_MaxDataRate = '0;
        sb.i_RX_ClockMode = 1'b0; sb.i_RX_PhaseClock = 1'b0;
        sb.i_Busy_SideBand = 1'b0; sb.i_falling_edge_busy = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset_state", int'(dut_vec()), 0);
        rst_n = 1'b1;

        // Basic negotiation: local 5/1/0, remote 3/1/1
        en = 1'b1; tick();
        send_req(3'd3, 1'b1, 1'b1);
        tick();
        check("t1_opcode", int'(sb.o_TX_SbMessage), 2);
        check("t1_valid_out", int'(sb.o_ValidOutDatat_Module), 1);
        check("t1_valid_params", int'(sb.o_ValidDataFieldParameters), 1);
        check("t1_vswing", int'(sb.o_TX_VoltageSwing), 0);
        check("t1_rate", int'(sb.o_MaxDataRate), 3);
        check("t1_clk", int'(sb.o_TX_ClockMode), 1);
        check("t1_ph", int'(sb.o_TX_PhaseClock), 0);
        sb.i_Busy_SideBand = 1'b1; tick(); tick();
        sb.i_Busy_SideBand = 1'b0; sb.i_falling_edge_busy = 1'b1; tick();
        sb.i_falling_edge_busy = 1'b0;
        check("t1_end", int'(resp_end), 1);
        check("t1_final", int'(final_rate), 3);
        check("t1_tx_released", int'(sb.o_ValidOutDatat_Module), 0);
        en = 1'b0; tick();
        check("t1_end_cleared", int'(resp_end), 0);
        check("t1_final_kept", int'(final_rate), 3);
        $display("txn: directed basic negotiation finished");

        // Zero remote rate -> single error pulse, no response
        en = 1'b1; tick();
        send_req(3'd0, 1'b1, 1'b1);
        errs = 0; seen = 0;
        repeat (6) begin
            tick();
            errs += int'(err_req);
            seen += int'(sb.o_ValidOutDatat_Module);
        end
        check("t2_err_pulses", errs, 1);
        check("t2_no_resp", seen, 0);
        en = 1'b0; tick();
        $display("txn: directed zero-rate error finished");

        // Timeout with no request
        en = 1'b1; tick();
        errs = 0; first = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (err_req) begin
                errs++;
                if (first == 0) first = k;
            end
        end
        check("t3_timeout_cycle", first, TMO + 1);
        check("t3_timeout_pulses", errs, 1);
        en = 1'b0; tick();
        $display("txn: directed timeout finished");

        // Busy held for 5 cycles after the request
        en = 1'b1; tick();
        send_req(3'd6, 1'b1, 1'b1);
        sb.i_Busy_SideBand = 1'b1;
        early = 0;
        repeat (5) begin
            tick();
            early += int'(sb.o_ValidOutDatat_Module);
        end
        check("t4_not_early", early, 0);
        sb.i_Busy_SideBand = 1'b0; tick();
        check("t4_first_free", int'(sb.o_ValidOutDatat_Module), 1);
        check("t4_rate", int'(sb.o_MaxDataRate), 5);
        check("t4_ph", int'(sb.o_TX_PhaseClock), 0);
        $display("txn: directed busy hold finished");

        // Enable drop during SEND_RESP together with falling edge of busy
        en = 1'b0; sb.i_falling_edge_busy = 1'b1; tick();
        sb.i_falling_edge_busy = 1'b0;
        check("t5_tx_off", int'(dut_vec() >> 8), 0);
        check("t5_final_kept", int'(final_rate), 3);
        check("t5_no_end", int'(resp_end), 0);
        $display("txn: directed abort finished");

        // Response opcode ignored, following request handled
        en = 1'b1; tick();
        sb.i_msg_valid = 1'b1; sb.i_RX_SbMessage = 4'b0010; sb.i_RX_MaxDataRate = 3'd7;
        sb.i_RX_ClockMode = 1'b1; sb.i_RX_PhaseClock = 1'b1;
        tick();
        sb.i_msg_valid = 1'b0; sb.i_RX_SbMessage = 4'b0000;
        tick();
        check("t6_resp_ignored", int'(sb.o_ValidOutDatat_Module), 0);
        send_req(3'd2, 1'b0, 1'b1);
        tick();
        check("t6_valid", int'(sb.o_ValidOutDatat_Module), 1);
        check("t6_rate", int'(sb.o_MaxDataRate), 2);
        check("t6_clk", int'(sb.o_TX_ClockMode), 0);
        sb.i_falling_edge_busy = 1'b1; tick();
        sb.i_falling_edge_busy = 1'b0;
        check("t6_final", int'(final_rate), 2);
        check("t6_end", int'(resp_end), 1);
        $display("txn: directed ignored-opcode finished");

        // Asynchronous reset mid-exchange
        en = 1'b0; tick();
        en = 1'b1; tick();
        send_req(3'd4, 1'b1, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1 check("t7_async_reset", int'(dut_vec()), 0);
        tick();
        rst_n = 1'b1;
        en = 1'b0; tick();
        $display("txn: directed async reset finished");

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (en) begin
                if ($urandom_range(0, 99) < 3) en = 1'b0;
            end else if ($urandom_range(0, 99) < 40) begin
                en = 1'b1;
            end
            if (!en && $urandom_range(0, 3) == 0) begin
                loc_rate = 3'($urandom_range(0, 7));
                loc_clk  = 1'($urandom_range(0, 1));
                loc_ph   = 1'($urandom_range(0, 1));
            end
            sb.i_msg_valid         = ($urandom_range(0, 99) < 40);
            sb.i_RX_SbMessage      = 4'($urandom_range(0, 3));
            sb.i_RX_MaxDataRate    = 3'($urandom_range(0, 7));
            sb.i_RX_ClockMode      = 1'($urandom_range(0, 1));
            sb.i_RX_PhaseClock     = 1'($urandom_range(0, 1));
            sb.i_Busy_SideBand     = 1'($urandom_range(0, 1));
            sb.i_falling_edge_busy = ($urandom_range(0, 4) == 0);
            tick();
        end

        en = 1'b0; sb.i_msg_valid = 1'b0; sb.i_falling_edge_busy = 1'b0;
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mbinit_param_responder.md
# mbinit_param_responder

Responder half of the MBINIT.PARAM sideband exchange. It waits for the partner's MBINIT.PARAM configuration_req and captures the advertised capabilities. It then resolves them against local capabilities, returns a configuration_resp carrying the negotiated values, and reports completion or a training error to the MBINIT sequencer. It sits beside the PARAM initiator under MBINIT and shares the sideband TX/RX message bus with it.

## Interface
- TIMEOUT_CYCLES, 4095: cycles allowed in WAIT_REQ before a training error is raised; must be ≥ 1.
- CNT_W, 12: width of the timeout counter; 2^CNT_W must exceed TIMEOUT_CYCLES.

Ports:
- CLK  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_MBINIT_Start_en  in  1  level enable; low aborts to IDLE.
- i_RX_SbMessage  in  4  decoded RX sideband opcode.
- i_msg_valid  in  1  i_RX_SbMessage and the i_RX_* fields are valid this cycle.
- i_RX_MaxDataRate  in  3  partner max data rate code.
- i_RX_ClockMode  in  1  partner clock mode request.
- i_RX_PhaseClock  in  1  partner clock phase request.
- i_Local_MaxDataRate  in  3  local max data rate code; must be static while enabled.
- i_Local_ClockMode  in  1  local clock mode support.
- i_Local_PhaseClock  in  1  local phase clock support.
- i_Busy_SideBand  in  1  sideband TX busy.
- i_falling_edge_busy  in  1  one-cycle pulse when the sideband TX finishes a message.
- o_TX_SbMessage  out  4  TX opcode.
- o_ValidOutDatat_Module  out  1  TX message request.
- o_ValidDataFieldParameters  out  1  TX data field carries parameters.
- o_TX_VoltageSwing  out  5  always 0 in resp.
- o_MaxDataRate  out  3  negotiated rate in resp.
- o_TX_ClockMode  out  1  negotiated clock mode in resp.
- o_TX_PhaseClock  out  1  negotiated phase in resp.
- o_Final_MaxDataRate  out  3  held negotiated rate.
- o_MBINIT_PARAM_Resp_end  out  1  responder done (level).
- o_train_error_req  out  1  one-cycle error pulse.

## Operation
- Opcodes:
  - configuration_req = 4'b0001
  - configuration_resp = 4'b0010
- States: IDLE, WAIT_REQ, RESOLVE, SEND_RESP, DONE, ERROR.
- IDLE -> WAIT_REQ when i_MBINIT_Start_en=1. The timeout counter clears on this transition.
- WAIT_REQ:
  - On i_msg_valid && opcode==req, capture i_RX_MaxDataRate, i_RX_ClockMode and i_RX_PhaseClock into registers, then go to RESOLVE.
  - Other opcodes are ignored.
  - The counter increments each cycle; when it reaches TIMEOUT_CYCLES, go to ERROR.
- RESOLVE: one cycle, computing from the captured values:
  - rate = min(captured rate, i_Local_MaxDataRate)
  - clk = captured ClockMode & i_Local_ClockMode
  - ph = captured PhaseClock & i_Local_PhaseClock
  - If rate==0, go to ERROR.
  - Else, if i_Busy_SideBand=0, go to SEND_RESP; otherwise stay in RESOLVE until busy drops.
- SEND_RESP:
  - Drive opcode=resp, both valid outputs=1, and fields = {0, rate, clk, ph}, held every cycle.
  - On i_falling_edge_busy, go to DONE; o_Final_MaxDataRate <= rate.
- DONE: o_MBINIT_PARAM_Resp_end=1; hold until enable drops.
- ERROR: o_train_error_req=1 for exactly one cycle on entry; hold until enable drops.
- Enable low in any state -> IDLE next cycle. All TX outputs and end go to 0; o_Final_MaxDataRate is retained.
- A req arriving while in RESOLVE, SEND_RESP or DONE is ignored.

## Timing
- All outputs are registered and decoded from NS, so they are valid in the cycle the state is entered.
- Reset values: every output is 0, including o_Final_MaxDataRate; CS=IDLE; captured regs and counter are 0.
- Latency:
  - req valid at cycle t -> RESOLVE at t+1.
  - resp outputs first high at t+2 if not busy.
- Timeout: the error pulse appears TIMEOUT_CYCLES+1 cycles after WAIT_REQ entry.
- Simultaneous events:
  - req valid and timeout in the same cycle: req wins.
  - Enable low and i_falling_edge_busy in the same cycle: IDLE wins, and o_Final_MaxDataRate is not updated.
- Asynchronous reset mid-exchange: immediate return to IDLE with all outputs 0.

## Structure
- Shared MBINIT package holds:
  - sideband opcode constants (req/resp)
  - data rate code width
  - state encodings
- Natural sub-module: mbinit_param_resolver. Combinational min/AND resolution plus the rate==0 error flag; reusable by the initiator's checker.

## Test plan
- Local 3'd5 / ClockMode 1 / PhaseClock 0; remote req {3'd3, 1, 1} -> resp with rate 3, clk 1, ph 0. After the busy falling edge: end=1 and o_Final_MaxDataRate=3.
- Remote rate 3'd0 -> no resp driven; o_train_error_req pulses once; state holds in ERROR until enable is low.
- TIMEOUT_CYCLES=8 with no req -> error pulse exactly 9 cycles after WAIT_REQ entry.
- i_Busy_SideBand=1 for 5 cycles after the req -> resp asserted on the first non-busy cycle, not earlier.
- Enable dropped during SEND_RESP -> all TX outputs 0 next cycle; o_Final_MaxDataRate unchanged.
- Opcode 4'b0010 with valid in WAIT_REQ -> ignored; a following req is handled normally.
